branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 89 ++++++++
 tb/tb_branch_resolver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: FIFO of in-flight predictions checked against execute results, with redirect, flush and statistics
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              predValid,
  input  logic              predTaken,
  input  logic [ADDR_W-1:0] predPC,
  input  logic [ADDR_W-1:0] predTarget,
  output logic              predReady,
  input  logic              resValid,
  input  logic              resTaken,
  input  logic [ADDR_W-1:0] resTarget,
  output logic              isBranch,
  output logic              branchTaken,
  output logic              redirectValid,
  output logic [ADDR_W-1:0] redirectPC,
  output logic              flush,
  output logic [15:0]       mispredictCount,
  output logic              protocolError
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic {S_IDLE, S_FLUSH} state_t;
  state_t            r_state;
  logic [FW-1:0]     r_fcnt;
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_cnt;
  logic              r_taken  [DEPTH];
  logic [ADDR_W-1:0] r_pc     [DEPTH];
  logic [ADDR_W-1:0] r_target [DEPTH];
  logic              w_idle, w_enq, w_res, w_err, w_mis;
  logic [ADDR_W-1:0] w_cpc;
  assign w_idle    = r_state == S_IDLE;
  assign predReady = w_idle && !r_cnt[PW];
  assign w_enq     = predValid && predReady;
  assign w_res     = resValid && w_idle && r_cnt != '0;
  assign w_err     = resValid && w_idle && r_cnt == '0;
  assign w_mis     = w_res && (resTaken != r_taken[r_rptr] || (resTaken && resTarget != r_target[r_rptr]));
  assign w_cpc     = resTaken ? resTarget : r_pc[r_rptr] + ADDR_W'(4);
  assign flush     = r_state == S_FLUSH;
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_taken[r_wptr]  <= predTaken;
      r_pc[r_wptr]     <= predPC;
      r_target[r_wptr] <= predTarget;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_fcnt          <= '0;
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_cnt           <= '0;
      isBranch        <= 1'b0;
      branchTaken     <= 1'b0;
      redirectValid   <= 1'b0;
      redirectPC      <= '0;
      mispredictCount <= '0;
      protocolError   <= 1'b0;
    end else begin
      isBranch        <= w_res;
      branchTaken     <= w_res && resTaken;
      redirectValid   <= w_mis;
      redirectPC      <= w_mis ? w_cpc : redirectPC;
      mispredictCount <= (w_mis && mispredictCount != 16'hFFFF) ? mispredictCount + 16'd1 : mispredictCount;
      protocolError   <= protocolError || w_err;
      if (w_mis) begin
        r_state <= S_FLUSH;
        r_fcnt  <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_cnt   <= '0;
      end else if (!w_idle) begin
        r_fcnt  <= r_fcnt + FW'(1);
        r_state <= (r_fcnt == FW'(FLUSH_CYCLES - 1)) ? S_IDLE : S_FLUSH;
      end else begin
        r_wptr <= r_wptr + PW'(w_enq);
        r_rptr <= r_rptr + PW'(w_res);
        r_cnt  <= r_cnt + CW'(w_enq) - CW'(w_res);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: vector table, reset corner cases and random stimulus against a queue-based reference model
module tb_branch_resolver;
  logic        clk = 0, rst = 1;
  logic        predValid = 0, predTaken = 0, resValid = 0, resTaken = 0;
  logic [31:0] predPC = 0, predTarget = 0, resTarget = 0;
  logic        predReady, isBranch, branchTaken, redirectValid, flush, protocolError;
  logic [31:0] redirectPC;
  logic [15:0] mispredictCount;
  int n_cmp = 0, n_bad = 0;

  branch_resolver #(.DEPTH(4), .ADDR_W(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .predValid(predValid), .predTaken(predTaken), .predPC(predPC),
    .predTarget(predTarget), .predReady(predReady), .resValid(resValid), .resTaken(resTaken),
    .resTarget(resTarget), .isBranch(isBranch), .branchTaken(branchTaken),
    .redirectValid(redirectValid), .redirectPC(redirectPC), .flush(flush),
    .mispredictCount(mispredictCount), .protocolError(protocolError));

  always #5 clk = ~clk;

  typedef struct {logic t; logic [31:0] pc, tg;} ent_t;
  ent_t q[$];
  int   fl = 0, m_cnt = 0;
  bit   m_err = 0, m_isb = 0, m_bt = 0, m_rv = 0;
  logic [31:0] m_rpc = 0;

  typedef struct {
    logic pv, pt; logic [31:0] ppc, ptg; logic rv, rt; logic [31:0] rtg;
    logic isb, bt, rvl; logic [31:0] rpc; logic fl, rdy; logic [15:0] cnt; logic err;
  } vec_t;
  vec_t tbl[23];

  function automatic vec_t v(logic pv, logic pt, logic [31:0] ppc, logic [31:0] ptg, logic rv, logic rt,
                             logic [31:0] rtg, logic isb, logic bt, logic rvl, logic [31:0] rpc,
                             logic fl_e, logic rdy, logic [15:0] cnt, logic err);
    vec_t r;
    r.pv = pv; r.pt = pt; r.ppc = ppc; r.ptg = ptg; r.rv = rv; r.rt = rt; r.rtg = rtg;
    r.isb = isb; r.bt = bt; r.rvl = rvl; r.rpc = rpc; r.fl = fl_e; r.rdy = rdy; r.cnt = cnt; r.err = err;
    return r;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic model_reset();
    q.delete(); fl = 0; m_cnt = 0; m_err = 0; m_isb = 0; m_bt = 0; m_rv = 0;
  endtask

  task automatic cyc(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptg,
                     input logic rv, input logic rt, input logic [31:0] rtg);
    ent_t h;
    bit idle, enq, res, mis;
    predValid = pv; predTaken = pt; predPC = ppc; predTarget = ptg;
    resValid = rv; resTaken = rt; resTarget = rtg;
    idle = fl == 0;
    enq = pv && idle && q.size() < 4;
    res = rv && idle && q.size() > 0;
    if (rv && idle && q.size() == 0) m_err = 1;
    mis = 0;
    if (res) begin
      h = q.pop_front();
      mis = (rt != h.t) || (rt && rtg != h.tg);
      if (mis) m_rpc = rt ? rtg : h.pc + 32'd4;
    end
    m_isb = res; m_bt = res && rt; m_rv = mis;
    if (enq) q.push_back('{pt, ppc, ptg});
    if (fl > 0) fl--;
    else if (mis) begin
      q.delete(); fl = 2;
      if (m_cnt < 65535) m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic model_check();
    chk("isBranch", isBranch, m_isb);
    chk("branchTaken", branchTaken, m_bt);
    chk("redirectValid", redirectValid, m_rv);
    if (m_rv) chk("redirectPC", redirectPC, m_rpc);
    chk("flush", flush, fl > 0);
    chk("predReady", predReady, fl == 0 && q.size() < 4);
    chk("mispredictCount", mispredictCount, m_cnt);
    chk("protocolError", protocolError, m_err);
  endtask

  initial begin
    ent_t h;
    logic pv, pt, rv, rt;
    logic [31:0] ppc, ptg, rtg;
    tbl[0]  = v(1,1,32'h100,32'h200, 0,0,0,           0,0,0,0,        0,1,0,0);
    tbl[1]  = v(0,0,0,0,             1,1,32'h200,     1,1,0,0,        0,1,0,0);
    tbl[2]  = v(1,0,32'h100,0,       0,0,0,           0,0,0,0,        0,1,0,0);
    tbl[3]  = v(0,0,0,0,             1,1,32'h300,     1,1,1,32'h300,  1,0,1,0);
    tbl[4]  = v(1,0,0,0,             1,1,0,           0,0,0,0,        1,0,1,0);
    tbl[5]  = v(0,0,0,0,             0,0,0,           0,0,0,0,        0,1,1,0);
    tbl[6]  = v(1,1,32'hFFFFFFFC,32'h40, 0,0,0,       0,0,0,0,        0,1,1,0);
    tbl[7]  = v(0,0,0,0,             1,0,0,           1,0,1,0,        1,0,2,0);
    tbl[8]  = v(0,0,0,0,             0,0,0,           0,0,0,0,        1,0,2,0);
    tbl[9]  = v(0,0,0,0,             0,0,0,           0,0,0,0,        0,1,2,0);
    tbl[10] = v(0,0,0,0,             1,1,32'h10,      0,0,0,0,        0,1,2,1);
    tbl[11] = v(0,0,0,0,             0,0,0,           0,0,0,0,        0,1,2,1);
    tbl[12] = v(1,0,32'h10,0,        0,0,0,           0,0,0,0,        0,1,2,1);
    tbl[13] = v(1,1,32'h20,32'h120,  0,0,0,           0,0,0,0,        0,1,2,1);
    tbl[14] = v(1,0,32'h30,0,        0,0,0,           0,0,0,0,        0,1,2,1);
    tbl[15] = v(1,1,32'h40,32'h140,  0,0,0,           0,0,0,0,        0,0,2,1);
    tbl[16] = v(1,0,32'h99,0,        1,0,0,           1,0,0,0,        0,1,2,1);
    tbl[17] = v(1,1,32'h50,32'h150,  1,1,32'h120,     1,1,0,0,        0,1,2,1);
    tbl[18] = v(1,0,32'h60,0,        1,0,0,           1,0,0,0,        0,1,2,1);
    tbl[19] = v(1,0,32'h70,0,        1,1,32'h140,     1,1,0,0,        0,1,2,1);
    tbl[20] = v(0,0,0,0,             1,0,0,           1,0,1,32'h54,   1,0,3,1);
    tbl[21] = v(0,0,0,0,             0,0,0,           0,0,0,0,        1,0,3,1);
    tbl[22] = v(0,0,0,0,             0,0,0,           0,0,0,0,        0,1,3,1);

    #2;
    chk("reset isBranch", isBranch, 0);
    chk("reset flush", flush, 0);
    chk("reset count", mispredictCount, 0);
    chk("reset redirectPC", redirectPC, 0);
    chk("reset protocolError", protocolError, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("post-reset predReady", predReady, 1);
    chk("post-reset redirectValid", redirectValid, 0);

    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].pv, tbl[i].pt, tbl[i].ppc, tbl[i].ptg, tbl[i].rv, tbl[i].rt, tbl[i].rtg);
      chk($sformatf("vec%0d isBranch", i), isBranch, tbl[i].isb);
      chk($sformatf("vec%0d branchTaken", i), branchTaken, tbl[i].bt);
      chk($sformatf("vec%0d redirectValid", i), redirectValid, tbl[i].rvl);
      if (tbl[i].rvl) chk($sformatf("vec%0d redirectPC", i), redirectPC, tbl[i].rpc);
      chk($sformatf("vec%0d flush", i), flush, tbl[i].fl);
      chk($sformatf("vec%0d predReady", i), predReady, tbl[i].rdy);
      chk($sformatf("vec%0d count", i), mispredictCount, tbl[i].cnt);
      chk($sformatf("vec%0d protocolError", i), protocolError, tbl[i].err);
    end

    cyc(1,0,32'h500,0, 0,0,0);
    cyc(1,0,32'h600,0, 0,0,0);
    cyc(1,0,32'h800,0, 1,1,32'h700);
    chk("midflush flush", flush, 1);
    chk("midflush redirectPC", redirectPC, 32'h700);
    rst = 1;
    #1;
    chk("async rst flush", flush, 0);
    chk("async rst count", mispredictCount, 0);
    chk("async rst redirectValid", redirectValid, 0);
    chk("async rst predReady", predReady, 1);
    chk("async rst protocolError", protocolError, 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    cyc(0,0,0,0, 0,0,0);
    chk("release predReady", predReady, 1);
    chk("release isBranch", isBranch, 0);
    chk("release flush", flush, 0);
    chk("release redirectValid", redirectValid, 0);
    chk("release count", mispredictCount, 0);

    for (int i = 0; i < 3000; i++) begin
      pv  = $urandom_range(0, 1);
      pt  = $urandom_range(0, 1);
      ppc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      ptg = $urandom_range(0, 1) ? 32'h40 : 32'h80;
      rv  = $urandom_range(0, 99) < 45;
      rt  = $urandom_range(0, 1);
      rtg = $urandom_range(0, 1) ? 32'h40 : 32'hC0;
      if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
        h = q[0];
        rt = h.t;
        rtg = h.tg;
      end
      cyc(pv, pt, ppc, ptg, rv, rt, rtg);
      model_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
